dmem_responder: RTL and testbench

- Data-memory responder for the CPU's data port (d_addr / d_mem_in / d_mem_wen / d_mem_out).
- Holds a word-addressed single-port RAM array fronted by a small posted write buffer.
- Stores are accepted immediately and drained into the array in cycles when the CPU is not reading.
- Loads see the youngest buffered store by forwarding.

---
 rtl/dmem_responder.sv | 92 +++++++++
 tb/tb_dmem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM fronted by a posted write buffer with load forwarding.
// Optional DMEM_RANGE_CHECK_EN: out-of-range accesses are dropped/zeroed and flagged on d_mem_err.
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_mem_in,
    input  logic        d_mem_wen,
    input  logic        d_mem_ren,
    output logic [31:0] d_mem_out,
    output logic        d_mem_busy,
    output logic        wb_empty
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        d_mem_err
`endif
);
    localparam int PW = $clog2(WB_DEPTH);
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx_q [WB_DEPTH];
    logic [31:0]       dat_q [WB_DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, pos;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       fwd;
    logic              full, push, pop, oor;
    logic              unused_bits;

    assign idx  = d_addr[ADDR_W+1:2];
    assign full = count_q == (PW+1)'(WB_DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    assign oor         = |d_addr[31:ADDR_W+2];
    assign d_mem_err   = err_q;
    assign unused_bits = ^d_addr[1:0];
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{d_addr[1:0], d_addr[31:ADDR_W+2]};
`endif
    // A full buffer drains even under a load so busy never outlasts one cycle.
    assign push       = !rst && d_mem_wen && !full && !oor;
    assign pop        = !rst && count_q != '0 && (!d_mem_ren || full);
    assign d_mem_busy = !rst && full;
    assign wb_empty   = rst || count_q == '0;
    assign d_mem_out  = (rst || !d_mem_ren || oor) ? 32'h0 : fwd;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd = mem[idx];
        pos = head_q;
        for (int k = 0; k < WB_DEPTH; k++) begin
            pos = head_q + PW'(k);
            if ((PW+1)'(k) < count_q && idx_q[pos] == idx) fwd = dat_q[pos];
        end
    end

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[tail_q] <= idx;
            dat_q[tail_q] <= d_mem_in;
        end
        if (pop) mem[idx_q[head_q]] <= dat_q[head_q];
    end

`ifdef DMEM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if ((d_mem_wen || d_mem_ren) && oor) err_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scenario tasks with a queue-based scoreboard for dmem_responder loads and flags.
module tb_dmem_responder;
    localparam int WB = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_addr = '0;
    logic [31:0] d_mem_in = '0;
    logic        d_mem_wen = 1'b0;
    logic        d_mem_ren = 1'b0;
    logic [31:0] d_mem_out;
    logic        d_mem_busy;
    logic        wb_empty;
`ifdef DMEM_RANGE_CHECK_EN
    logic        d_mem_err;
`endif
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          checks = 0;
    int          errors = 0;

    dmem_responder #(.ADDR_W(10), .WB_DEPTH(WB)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_addr     (d_addr),
        .d_mem_in   (d_mem_in),
        .d_mem_wen  (d_mem_wen),
        .d_mem_ren  (d_mem_ren),
        .d_mem_out  (d_mem_out),
        .d_mem_busy (d_mem_busy),
        .wb_empty   (wb_empty)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .d_mem_err  (d_mem_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d_mem_ren = 1'b1; d_addr = 32'h10;
        step(); step();
        #1;
        checks++; if (d_mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", d_mem_busy); end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", wb_empty); end
        checks++; if (d_mem_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", d_mem_out); end
`ifdef DMEM_RANGE_CHECK_EN
        checks++; if (d_mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", d_mem_err); end
`endif
        d_mem_ren = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        d_addr = 32'h10; d_mem_in = 32'hDEADBEEF; d_mem_wen = 1'b1; d_mem_ren = 1'b0;
        step();
        d_mem_wen = 1'b0;
        checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL basic_empty1: got %b expected 0", wb_empty); end
        step();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL basic_empty2: got %b expected 1", wb_empty); end
        d_mem_ren = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL basic_load: got %h expected %h", d_mem_out, e); end
        d_mem_ren = 1'b0;
        step();
    endtask

    task automatic test_forward();
        d_mem_ren = 1'b1; d_addr = 32'h20; d_mem_in = 32'd1; d_mem_wen = 1'b1;
        step();
        d_mem_in = 32'd2;
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL fwd_first: got %h expected %h", d_mem_out, e); end
        step();
        d_mem_wen = 1'b0;
        exp_q.push_back(32'd2);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL fwd_youngest: got %h expected %h", d_mem_out, e); end
        checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL fwd_pending: got %b expected 0", wb_empty); end
        d_mem_ren = 1'b0;
        step(); step();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %b expected 1", wb_empty); end
        d_mem_ren = 1'b1;
        exp_q.push_back(32'd2);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL fwd_array: got %h expected %h", d_mem_out, e); end
    endtask

    task automatic test_full();
        d_mem_ren = 1'b1; d_mem_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_addr = 32'(i * 4); d_mem_in = 32'(100 + i);
            step();
        end
        d_addr = 32'h10; d_mem_in = 32'd104;
        checks++; if (d_mem_busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", d_mem_busy); end
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL full_load: got %h expected %h", d_mem_out, e); end
        step();
        checks++; if (d_mem_busy !== 1'b0) begin errors++; $display("FAIL full_busy_drop: got %b expected 0", d_mem_busy); end
        step();
        d_mem_wen = 1'b0; d_addr = 32'h4;
        checks++; if (d_mem_busy !== 1'b1) begin errors++; $display("FAIL full_accept5: got %b expected 1", d_mem_busy); end
        exp_q.push_back(32'd101);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL full_drain_load: got %h expected %h", d_mem_out, e); end
        step();
        checks++; if (d_mem_busy !== 1'b0) begin errors++; $display("FAIL full_busy_drop2: got %b expected 0", d_mem_busy); end
        d_mem_ren = 1'b0;
        step(); step(); step();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b expected 1", wb_empty); end
        d_mem_ren = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_addr = 32'(i * 4);
            exp_q.push_back(32'(100 + i));
            #1;
            e = exp_q.pop_front();
            checks++; if (d_mem_out !== e) begin errors++; $display("FAIL full_readback%0d: got %h expected %h", i, d_mem_out, e); end
        end
        d_mem_ren = 1'b0;
        step();
    endtask

    task automatic test_same_cycle();
        d_addr = 32'h30; d_mem_in = 32'hAAAA; d_mem_wen = 1'b1; d_mem_ren = 1'b0;
        step();
        d_mem_wen = 1'b0;
        step();
        d_mem_wen = 1'b1; d_mem_ren = 1'b1; d_mem_in = 32'h5555;
        exp_q.push_back(32'hAAAA);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL same_pre: got %h expected %h", d_mem_out, e); end
        step();
        d_mem_wen = 1'b0;
        exp_q.push_back(32'h5555);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL same_post: got %h expected %h", d_mem_out, e); end
        d_mem_ren = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_discard();
        d_mem_ren = 1'b0; d_mem_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_addr = 32'h40 + 32'(i * 4); d_mem_in = 32'(17 * (i + 1));
            step();
        end
        d_mem_wen = 1'b0;
        step(); step(); step();
        d_mem_ren = 1'b1; d_mem_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_addr = 32'h40 + 32'(i * 4); d_mem_in = 32'hA0 + 32'(i);
            step();
        end
        d_mem_wen = 1'b0;
        checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL disc_pending: got %b expected 0", wb_empty); end
        rst = 1'b1; d_mem_ren = 1'b0;
        step();
        d_mem_ren = 1'b1;
        #1;
        checks++; if (d_mem_out !== 32'h0) begin errors++; $display("FAIL disc_rst_out: got %h expected 0", d_mem_out); end
        rst = 1'b0; d_mem_ren = 1'b0;
        #1;
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL disc_empty: got %b expected 1", wb_empty); end
        checks++; if (d_mem_busy !== 1'b0) begin errors++; $display("FAIL disc_busy: got %b expected 0", d_mem_busy); end
        d_mem_ren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_addr = 32'h40 + 32'(i * 4);
            exp_q.push_back(32'(17 * (i + 1)));
            #1;
            e = exp_q.pop_front();
            checks++; if (d_mem_out !== e) begin errors++; $display("FAIL disc_load%0d: got %h expected %h", i, d_mem_out, e); end
        end
        d_mem_ren = 1'b0;
        step();
    endtask

    task automatic test_range();
`ifdef DMEM_RANGE_CHECK_EN
        d_addr = 32'h1000; d_mem_in = 32'h1234; d_mem_wen = 1'b1; d_mem_ren = 1'b0;
        step();
        d_mem_wen = 1'b0; d_addr = 32'h0;
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL range_dropped: got %b expected 1", wb_empty); end
        checks++; if (d_mem_err !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", d_mem_err); end
        step(); step();
        checks++; if (d_mem_err !== 1'b1) begin errors++; $display("FAIL range_err_held: got %b expected 1", d_mem_err); end
        d_addr = 32'h1000; d_mem_ren = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL range_load: got %h expected %h", d_mem_out, e); end
        d_mem_ren = 1'b0;
        step();
`else
        d_addr = 32'h1050; d_mem_in = 32'h0BADF00D; d_mem_wen = 1'b1; d_mem_ren = 1'b0;
        step();
        d_mem_wen = 1'b0;
        step(); step();
        d_addr = 32'h50; d_mem_ren = 1'b1;
        exp_q.push_back(32'h0BADF00D);
        #1;
        e = exp_q.pop_front();
        checks++; if (d_mem_out !== e) begin errors++; $display("FAIL alias_load: got %h expected %h", d_mem_out, e); end
        d_mem_ren = 1'b0;
        step();
`endif
    endtask

    task automatic test_random();
        logic [31:0] marr [8];
        int          mq_a [$];
        logic [31:0] mq_d [$];
        int          w;
        logic [31:0] dv, ex;
        logic        do_pop, do_push;
        d_mem_ren = 1'b0; d_mem_wen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_addr = 32'(i * 4); d_mem_in = 32'(i * 3 + 7); marr[i] = 32'(i * 3 + 7);
            step();
        end
        d_mem_wen = 1'b0;
        step(); step();
        for (int c = 0; c < 300; c++) begin
            w = int'($urandom_range(0, 7));
            dv = $urandom;
            d_addr = 32'(w * 4); d_mem_in = dv;
            d_mem_wen = 1'($urandom_range(0, 1));
            d_mem_ren = ($urandom_range(0, 3) != 0);
            ex = 32'h0;
            if (d_mem_ren) begin
                ex = marr[w];
                foreach (mq_a[j]) if (mq_a[j] == w) ex = mq_d[j];
            end
            exp_q.push_back(ex);
            #1;
            e = exp_q.pop_front();
            checks++; if (d_mem_out !== e) begin errors++; $display("FAIL rand_load c=%0d: got %h expected %h", c, d_mem_out, e); end
            checks++; if (d_mem_busy !== (mq_a.size() == WB)) begin errors++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, d_mem_busy, mq_a.size() == WB); end
            do_pop = mq_a.size() > 0 && (!d_mem_ren || mq_a.size() == WB);
            do_push = d_mem_wen && mq_a.size() != WB;
            step();
            if (do_pop) marr[mq_a.pop_front()] = mq_d.pop_front();
            if (do_push) begin
                mq_a.push_back(w);
                mq_d.push_back(dv);
            end
        end
        d_mem_wen = 1'b0; d_mem_ren = 1'b0;
        repeat (5) step();
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rand_empty: got %b expected 1", wb_empty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_full();
        test_same_cycle();
        test_reset_discard();
        test_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
